// File: rtl/l1_cache_pkg.sv
// Shared types and geometry helpers for the L1 data cache.
// States: IDLE (wait for CPU) | LOOKUP (tag compare) | FILL (block fetch from L2) | WTHRU (store to L2).
package l1_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    FILL   = 2'd2,
    WTHRU  = 2'd3
  } state_e;

  function automatic int LINES(input int cache_size, input int block_size);
    return cache_size / block_size;
  endfunction

  function automatic int OFFSET(input int block_size);
    return $clog2(block_size);
  endfunction

  // A single-line cache still gets a 1-bit index so port widths never collapse to zero
  function automatic int INDEX(input int cache_size, input int block_size);
    return (LINES(cache_size, block_size) > 1) ? $clog2(LINES(cache_size, block_size)) : 1;
  endfunction

  function automatic int TAG(input int addr_width, input int cache_size, input int block_size);
    return addr_width - OFFSET(block_size) - INDEX(cache_size, block_size);
  endfunction

  function automatic int WORDS_PER_BLOCK(input int data_width, input int block_size);
    return (block_size * 8) / data_width;
  endfunction

endpackage

// File: rtl/l1_tag_data_array.sv
// Tag/valid/data storage for the direct-mapped L1: combinational line read,
// single-word write and whole-block fill. Only valid bits are reset.
module l1_tag_data_array #(
  parameter int DATA_WIDTH = 32,
  parameter int N_LINES    = 4,
  parameter int IDX_W      = 2,
  parameter int TAG_W      = 4,
  parameter int N_WORDS    = 8,
  parameter int WSEL_W     = $clog2(N_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [IDX_W-1:0]              rd_idx_i,
  output logic [TAG_W-1:0]              rd_tag_o,
  output logic                          rd_valid_o,
  output logic [N_WORDS*DATA_WIDTH-1:0] rd_line_o,
  input  logic                          wr_en_i,
  input  logic [IDX_W-1:0]              wr_idx_i,
  input  logic [WSEL_W-1:0]             wr_word_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          fill_en_i,
  input  logic [IDX_W-1:0]              fill_idx_i,
  input  logic [TAG_W-1:0]              fill_tag_i,
  input  logic [N_WORDS*DATA_WIDTH-1:0] fill_block_i
);

  logic [TAG_W-1:0]              tag_q   [N_LINES];
  logic [N_WORDS*DATA_WIDTH-1:0] data_q  [N_LINES];
  logic [N_LINES-1:0]            valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fill_idx_i] <= 1'b1;
    end
  end

  // A fill replaces the line outright; there is never dirty data to write back
  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_block_i;
    end else if (wr_en_i) begin
      data_q[wr_idx_i][wr_word_i*DATA_WIDTH +: DATA_WIDTH] <= wr_data_i;
    end
  end

  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with one outstanding request.
// Optional macro L1_PERF_CNT_EN adds saturating hit_count/miss_count outputs.
module l1_dcache
  import l1_cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int CACHE_SIZE = 128,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic                    cpu_read,
  input  logic                    cpu_write,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_hit,
  output logic [ADDR_WIDTH-1:0]   l2_addr,
  output logic [DATA_WIDTH-1:0]   l2_wdata,
  output logic                    l2_read,
  output logic                    l2_write,
  input  logic [BLOCK_SIZE*8-1:0] l2_block_in,
  input  logic                    l2_block_valid,
  input  logic                    l2_ready
`ifdef L1_PERF_CNT_EN
  ,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
`endif
);

  localparam int N_LINES = LINES(CACHE_SIZE, BLOCK_SIZE);
  localparam int OFF_W   = OFFSET(BLOCK_SIZE);
  localparam int IDX_W   = INDEX(CACHE_SIZE, BLOCK_SIZE);
  localparam int TAG_W   = TAG(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE);
  localparam int N_WORDS = WORDS_PER_BLOCK(DATA_WIDTH, BLOCK_SIZE);
  localparam int WSEL_W  = $clog2(N_WORDS);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic [DATA_WIDTH-1:0]   req_wdata_q;
  logic                    req_write_q;
  logic                    hit_q;

  logic [TAG_W-1:0]              req_tag;
  logic [IDX_W-1:0]              req_idx;
  logic [WSEL_W-1:0]             req_wsel;
  logic [TAG_W-1:0]              rd_tag;
  logic                          rd_valid;
  logic [N_WORDS*DATA_WIDTH-1:0] rd_line;
  logic                          hit;
  logic                          wr_en;
  logic                          fill_en;
  logic [DATA_WIDTH-1:0]         hit_word;
  logic [DATA_WIDTH-1:0]         fill_word;
  logic                          unused_byte_sel;

  // Byte offset within a word plays no part in lookup or L2 traffic
  assign unused_byte_sel = ^cpu_addr[1:0];

  assign req_tag   = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx   = req_addr_q[OFF_W +: IDX_W];
  assign req_wsel  = req_addr_q[2 +: WSEL_W];
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign wr_en     = (state_q == LOOKUP) && req_write_q && hit;
  assign fill_en   = (state_q == FILL) && l2_block_valid && l2_ready;
  assign hit_word  = rd_line[req_wsel*DATA_WIDTH +: DATA_WIDTH];
  assign fill_word = l2_block_in[req_wsel*DATA_WIDTH +: DATA_WIDTH];

  l1_tag_data_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_LINES    (N_LINES),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W),
    .N_WORDS    (N_WORDS),
    .WSEL_W     (WSEL_W)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_idx_i     (req_idx),
    .rd_tag_o     (rd_tag),
    .rd_valid_o   (rd_valid),
    .rd_line_o    (rd_line),
    .wr_en_i      (wr_en),
    .wr_idx_i     (req_idx),
    .wr_word_i    (req_wsel),
    .wr_data_i    (req_wdata_q),
    .fill_en_i    (fill_en),
    .fill_idx_i   (req_idx),
    .fill_tag_i   (req_tag),
    .fill_block_i (l2_block_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_write_q <= 1'b0;
      hit_q       <= 1'b0;
      cpu_rdata   <= '0;
      cpu_ready   <= 1'b0;
      cpu_hit     <= 1'b0;
      l2_addr     <= '0;
      l2_wdata    <= '0;
      l2_read     <= 1'b0;
      l2_write    <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_read || cpu_write) begin
            req_addr_q  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            req_wdata_q <= cpu_wdata;
            req_write_q <= cpu_write;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (req_write_q) begin
            l2_addr  <= req_addr_q;
            l2_wdata <= req_wdata_q;
            l2_write <= 1'b1;
            hit_q    <= hit;
            state_q  <= WTHRU;
          end else if (hit) begin
            cpu_rdata <= hit_word;
            cpu_ready <= 1'b1;
            cpu_hit   <= 1'b1;
            state_q   <= IDLE;
          end else begin
            l2_addr <= {req_addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            l2_read <= 1'b1;
            state_q <= FILL;
          end
        end
        FILL: begin
          if (l2_block_valid && l2_ready) begin
            cpu_rdata <= fill_word;
            cpu_ready <= 1'b1;
            l2_read   <= 1'b0;
            state_q   <= IDLE;
          end
        end
        WTHRU: begin
          if (l2_ready) begin
            l2_write  <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_hit   <= hit_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef L1_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (cpu_ready) begin
      if (cpu_hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule
